// File: rtl/delay_probe_pkg.sv
// delay_probe_pkg: shared FSM states, status codes and default probe byte for delay_line_prober
package delay_probe_pkg;
    typedef enum logic [2:0] {IDLE, FLUSH, SEND, WAIT, FINISH} state_t;
    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_OK      = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_CORRUPT = 2'b11;
    localparam logic [7:0] PROBE_DEFAULT = 8'hA5;
endpackage

// File: rtl/delay_line_prober.sv
// delay_line_prober: flushes a delay line, injects one probe byte and counts cycles until it returns
//   clock, reset     : rising-edge clock, async active-high reset
//   start            : request a measurement (honoured only when idle)
//   echo_in          : output of the line under test
//   probe_out        : registered drive into the line input
//   busy, done       : measurement in progress / one-cycle completion pulse
//   status           : 00 none, 01 ok, 10 timeout, 11 corrupt
//   delay_count      : measured delay in cycles
module delay_line_prober
    import delay_probe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_DELAY = 127,
    parameter int CNT_W = 8,
    parameter logic [DATA_W-1:0] PROBE = DATA_W'(PROBE_DEFAULT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] echo_in,
    output logic [DATA_W-1:0] probe_out,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  delay_count
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DELAY);
    state_t state;
    logic [CNT_W-1:0] cnt;
    // cnt counts flush cycles in FLUSH and k (cycles since SEND) in SEND/WAIT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            probe_out   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= ST_NONE;
            delay_count <= '0;
        end else begin
            done      <= 1'b0;
            probe_out <= '0;
            case (state)
                IDLE: if (start) begin
                    state  <= FLUSH;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    status <= ST_NONE;
                end
                FLUSH: if (cnt == MAX_CNT) begin
                    state     <= SEND;
                    cnt       <= '0;
                    probe_out <= PROBE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // SEND shares WAIT's checks so a combinational loopback is measured as 0
                SEND, WAIT: if (echo_in == PROBE || echo_in != '0 || cnt == MAX_CNT) begin
                    state       <= FINISH;
                    done        <= 1'b1;
                    delay_count <= cnt;
                    status      <= echo_in == PROBE ? ST_OK : echo_in != '0 ? ST_CORRUPT : ST_TIMEOUT;
                end else begin
                    state <= WAIT;
                    cnt   <= cnt + 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_line_prober.sv
// tb_delay_line_prober: table-driven scoreboard bench for delay_line_prober with an N-stage line model
module tb_delay_line_prober;
    localparam int M = 127;
    localparam logic [7:0] PRB = 8'hA5;

    typedef struct {
        logic [1:0] st;
        logic [7:0] dly;
        int lat;
    } exp_t;

    typedef struct {
        int n;
        int mode;
        bit spam;
        logic [1:0] st;
        logic [7:0] dly;
        int lat;
    } vec_t;

    logic clock, reset, start, busy, done;
    logic [7:0] echo_in, probe_out, delay_count, raw;
    logic [1:0] status;

    int n, mode, n_checks, n_fail;
    logic [7:0] prev_delay;
    exp_t sb[$];
    bit [7:0] line [256];

    delay_line_prober dut (
        .clock(clock), .reset(reset), .start(start), .echo_in(echo_in),
        .probe_out(probe_out), .busy(busy), .done(done), .status(status),
        .delay_count(delay_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // delay_model: N registered stages; mode 1 ties echo to 0, mode 2 corrupts the probe to 8'h5A
    always @(posedge clock) begin
        line[0] <= probe_out;
        for (int i = 1; i < 256; i++) line[i] <= line[i-1];
    end
    always_comb begin
        raw = (n == 0) ? probe_out : line[n-1];
        echo_in = (mode == 1) ? 8'h00 : (mode == 2 && raw == PRB) ? 8'h5A : raw;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_probe_out"}, probe_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_status"}, status, 0);
        check({tag, "_delay_count"}, delay_count, 0);
    endtask

    task automatic run(input int nn, input int md, input bit spam, input int abort_at, input exp_t e);
        int lat, extra;
        bit got;
        exp_t x;
        n = nn;
        mode = md;
        @(negedge clock);
        start = 1'b1;
        sb.push_back(e);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 700) begin
            @(negedge clock);
            lat++;
            start = spam && (lat % 5 == 2);
            if (lat == 1) begin
                check("accept_busy", busy, 1);
                check("accept_status_cleared", status, 0);
                check("accept_delay_kept", delay_count, prev_delay);
            end
            if (lat == M + 1) check("flush_probe_zero", probe_out, 0);
            if (lat == M + 2) check("send_probe", probe_out, PRB);
            if (abort_at != 0 && lat == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                #1;
                check_reset_outputs("abort_immediate");
                repeat (3) @(negedge clock);
                check_reset_outputs("abort_held");
                reset = 1'b0;
                void'(sb.pop_back());
                prev_delay = 8'h00;
                return;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        x = sb.pop_front();
        if (!got) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("status", status, x.st);
        check("delay_count", delay_count, x.dly);
        check("latency", lat, x.lat);
        prev_delay = x.dly;
        @(negedge clock);
        check("done_one_cycle", done, 0);
        check("busy_dropped", busy, 0);
        if (spam) begin
            extra = 0;
            repeat (20) begin
                @(negedge clock);
                if (done || busy) extra++;
            end
            check("no_second_done", extra, 0);
        end
    endtask

    vec_t tbl [8];

    initial begin
        n_checks = 0;
        n_fail = 0;
        prev_delay = 8'h00;
        n = 0;
        mode = 0;
        start = 1'b0;
        reset = 1'b1;
        tbl[0] = '{30,  0, 1'b0, 2'b01, 8'd30,  160};
        tbl[1] = '{0,   0, 1'b0, 2'b01, 8'd0,   130};
        tbl[2] = '{0,   1, 1'b0, 2'b10, 8'd127, 257};
        tbl[3] = '{45,  2, 1'b0, 2'b11, 8'd45,  175};
        tbl[4] = '{60,  0, 1'b1, 2'b01, 8'd60,  190};
        tbl[5] = '{127, 0, 1'b0, 2'b01, 8'd127, 257};
        tbl[6] = '{128, 0, 1'b0, 2'b10, 8'd127, 257};
        tbl[7] = '{0,   2, 1'b0, 2'b11, 8'd0,   130};
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        for (int i = 0; i < 8; i++)
            run(tbl[i].n, tbl[i].mode, tbl[i].spam, 0, '{tbl[i].st, tbl[i].dly, tbl[i].lat});
        run(90, 0, 1'b0, M + 2 + 40, '{2'b01, 8'd90, M + 93});
        run(90, 0, 1'b0, 0, '{2'b01, 8'd90, M + 93});
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
